ddrio_tx_train: RTL



---
 rtl/ddrio_tx_train.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ddrio_tx_train.sv
// ddrio_tx_train: transmit word-alignment trainer for the x2 DDR data IO pair.
//   Sends KEY_WORD on both lanes and pulses align_ol to slip the output word
//   boundary until rx_locked is seen; otherwise passes user words through a
//   word-rate valid/ready handshake.
// Ports:
//   geclk_ol_buf_o      fast output clock
//   align_rst_ol        async active-high reset
//   train_start         training request (ignored while training)
//   rx_locked           key-detector lock flag, sampled at the decision boundary
//   tx_valid/tx_ready   user word handshake, tx_ready strobes on word boundaries
//   tx_d0/tx_d1/tx_oe   user word per lane and its drive enable
//   d_0/d_1, t_0/t_1    gearbox data words and tristate words (1 = drive)
//   align_ol            one-cycle word-boundary slip pulse
//   train_busy/done/fail  registered status flags
//   slip_cnt            slips issued in the current or last training run
module ddrio_tx_train #(
    parameter int unsigned RATIO     = 4,
    parameter logic [7:0]  KEY_WORD  = 8'hB8,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned SLIP_GAP  = 8,
    parameter int unsigned MAX_SLIPS = 8
) (
    input  logic       geclk_ol_buf_o,
    input  logic       align_rst_ol,
    input  logic       train_start,
    input  logic       rx_locked,
    input  logic       tx_valid,
    input  logic [7:0] tx_d0,
    input  logic [7:0] tx_d1,
    input  logic       tx_oe,
    output logic       tx_ready,
    output logic [7:0] d_0,
    output logic [7:0] d_1,
    output logic [3:0] t_0,
    output logic [3:0] t_1,
    output logic       align_ol,
    output logic       train_busy,
    output logic       train_done,
    output logic       train_fail,
    output logic [3:0] slip_cnt
);
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int GW = $clog2(SLIP_GAP + 1);

    typedef enum logic [2:0] {IDLE, TRAIN, SLIP, DONE, FAIL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q;
    logic [CW-1:0] settle_q;
    logic [GW-1:0] gap_q;
    logic [3:0]    slip_cnt_q;
    logic [7:0]    d0_q, d1_q;
    logic [3:0]    t0_q, t1_q;
    logic          align_q, busy_q, done_q, fail_q;
    logic          user_mode, bnd, accept, last_word, gap_end, start, slip_go;

    assign bnd       = ph_q == PW'(RATIO - 1);
    assign user_mode = state_q inside {IDLE, DONE, FAIL};
    assign tx_ready  = user_mode && bnd;
    assign accept    = tx_ready && tx_valid;
    assign last_word = settle_q == CW'(SETTLE - 1);
    assign gap_end   = gap_q == GW'(SLIP_GAP - 1);
    assign start     = user_mode && train_start;
    assign slip_go   = state_q == TRAIN && state_d == SLIP;

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = TRAIN;
        else if (state_q == TRAIN && bnd && last_word)
            state_d = rx_locked ? DONE : (slip_cnt_q == 4'(MAX_SLIPS) ? FAIL : SLIP);
        else if (state_q == SLIP && gap_end)
            state_d = TRAIN;
    end

    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            settle_q   <= '0;
            gap_q      <= '0;
            slip_cnt_q <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            align_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= bnd ? '0 : ph_q + 1'b1;
            busy_q  <= state_d inside {TRAIN, SLIP};
            done_q  <= state_d == DONE;
            fail_q  <= state_d == FAIL;
            align_q <= slip_go;
            // FAIL is taken at MAX_SLIPS, so the guard only keeps the count from ever wrapping
            if (start)
                slip_cnt_q <= '0;
            else if (slip_go && slip_cnt_q != 4'(MAX_SLIPS))
                slip_cnt_q <= slip_cnt_q + 1'b1;
            // only key words loaded while in TRAIN count toward the settle window
            if (state_d == TRAIN && state_q != TRAIN)
                settle_q <= '0;
            else if (state_q == TRAIN && bnd)
                settle_q <= settle_q + 1'b1;
            gap_q <= (state_q == SLIP) ? gap_q + 1'b1 : '0;
            if (bnd) begin
                d0_q <= user_mode ? (accept ? tx_d0 : 8'h00) : KEY_WORD;
                d1_q <= user_mode ? (accept ? tx_d1 : 8'h00) : KEY_WORD;
                t0_q <= user_mode ? {4{accept && tx_oe}} : 4'hF;
                t1_q <= user_mode ? {4{accept && tx_oe}} : 4'hF;
            end
        end
    end

    assign d_0        = d0_q;
    assign d_1        = d1_q;
    assign t_0        = t0_q;
    assign t_1        = t1_q;
    assign align_ol   = align_q;
    assign train_busy = busy_q;
    assign train_done = done_q;
    assign train_fail = fail_q;
    assign slip_cnt   = slip_cnt_q;
endmodule
